// File: rtl/regfile_pkg.sv
// Shared types, default sizes and helpers for the multi-port integer register file.
package regfile_pkg;

  localparam int unsigned DEF_WIDTH   = 32;
  localparam int unsigned DEF_ENTRIES = 32;
  localparam int unsigned DEF_AW      = 5;

  // Upper bound for the onehot helper; callers truncate to their own entry count.
  localparam int unsigned MAX_AW      = 10;
  localparam int unsigned MAX_ENTRIES = 1 << MAX_AW;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  function automatic logic [MAX_ENTRIES-1:0] addr_onehot(input logic [MAX_AW-1:0] addr);
    return MAX_ENTRIES'(1) << addr;
  endfunction

endpackage

// File: rtl/regfile_mp_if.sv
// Read/write/reserve/clear bus of the multi-port register file.
interface regfile_mp_if #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned AW     = 5,
  parameter int unsigned NUM_RD = 2,
  parameter int unsigned NUM_WR = 2
);
  logic [NUM_RD*AW-1:0]    rd_addr;
  logic [NUM_RD*WIDTH-1:0] rd_data;
  logic [NUM_RD-1:0]       rd_pending;
  logic [NUM_WR-1:0]       wr_en;
  logic [NUM_WR*AW-1:0]    wr_addr;
  logic [NUM_WR*WIDTH-1:0] wr_data;
  logic                    rsv_en;
  logic [AW-1:0]           rsv_addr;
  logic                    clr_req;
  logic                    clr_busy;
  logic                    clr_done;

  modport master (
    output rd_addr, wr_en, wr_addr, wr_data, rsv_en, rsv_addr, clr_req,
    input  rd_data, rd_pending, clr_busy, clr_done
  );

  modport slave (
    input  rd_addr, wr_en, wr_addr, wr_data, rsv_en, rsv_addr, clr_req,
    output rd_data, rd_pending, clr_busy, clr_done
  );
endinterface

// File: rtl/regfile_wr_arb.sv
// Per-entry write strobe and data select; the highest enabled port index wins.
module regfile_wr_arb
  import regfile_pkg::*;
#(
  parameter int unsigned WIDTH   = DEF_WIDTH,
  parameter int unsigned ENTRIES = DEF_ENTRIES,
  parameter int unsigned AW      = DEF_AW,
  parameter int unsigned NUM_WR  = 2
) (
  input  logic [NUM_WR-1:0]              wr_en,
  input  logic [NUM_WR*AW-1:0]           wr_addr,
  input  logic [NUM_WR*WIDTH-1:0]        wr_data,
  output logic [ENTRIES-1:0]             strobe,
  output logic [ENTRIES-1:0][WIDTH-1:0]  sel_data
);

  logic [NUM_WR-1:0][ENTRIES-1:0] port_hit;

  for (genvar p = 0; p < NUM_WR; p++) begin : g_hit
    assign port_hit[p] = ENTRIES'(addr_onehot(MAX_AW'(wr_addr[p*AW +: AW])))
                         & {ENTRIES{wr_en[p]}};
  end

  // Ascending scan so a later (higher) port overrides earlier ones.
  always_comb begin
    strobe   = '0;
    sel_data = '0;
    for (int p = 0; p < int'(NUM_WR); p++) begin
      for (int e = 0; e < int'(ENTRIES); e++) begin
        if (port_hit[p][e]) begin
          strobe[e]   = 1'b1;
          sel_data[e] = wr_data[p*WIDTH +: WIDTH];
        end
      end
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with x0 handling, write bypass, pending scoreboard and soft clear.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int unsigned WIDTH    = DEF_WIDTH,
  parameter int unsigned ENTRIES  = DEF_ENTRIES,
  parameter int unsigned AW       = DEF_AW,
  parameter int unsigned NUM_RD   = 2,
  parameter int unsigned NUM_WR   = 2,
  parameter int unsigned ZERO_REG = 1,
  parameter int unsigned BYPASS   = 1
) (
  input logic         clk,
  input logic         areset,
  regfile_mp_if.slave bus
);

  logic [ENTRIES-1:0][WIDTH-1:0] mem;
  logic [ENTRIES-1:0][WIDTH-1:0] sel_data;
  logic [ENTRIES-1:0]            pending;
  logic [ENTRIES-1:0]            strobe;
  logic [ENTRIES-1:0]            rsv_oh;
  state_t                        state, state_next;
  logic [AW-1:0]                 cnt, cnt_next;
  logic                          busy_q, done_q, busy_next, done_next;

  regfile_wr_arb #(
    .WIDTH(WIDTH), .ENTRIES(ENTRIES), .AW(AW), .NUM_WR(NUM_WR)
  ) u_arb (
    .wr_en   (bus.wr_en),
    .wr_addr (bus.wr_addr),
    .wr_data (bus.wr_data),
    .strobe  (strobe),
    .sel_data(sel_data)
  );

  assign rsv_oh = ENTRIES'(addr_onehot(MAX_AW'(bus.rsv_addr)));

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state  <= state_next;
      cnt    <= cnt_next;
      busy_q <= busy_next;
      done_q <= done_next;
    end
  end

  // Busy/done are registered from the next-state so they line up with the CLEAR cycles.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      ST_IDLE: begin
        if (bus.clr_req) begin
          state_next = ST_CLEAR;
          cnt_next   = '0;
        end
      end
      ST_CLEAR: begin
        cnt_next = cnt + AW'(1);
        if (cnt == AW'(ENTRIES - 1)) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
    busy_next = (state_next == ST_CLEAR);
    done_next = busy_next && (cnt_next == AW'(ENTRIES - 1));
  end

  assign bus.clr_busy = busy_q;
  assign bus.clr_done = done_q;

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      mem     <= '0;
      pending <= '0;
    end else if (state == ST_CLEAR) begin
      mem[cnt] <= '0;
    end else begin
      for (int e = 0; e < int'(ENTRIES); e++) begin
        if (!(ZERO_REG != 0 && e == 0)) begin
          if (strobe[e]) mem[e] <= sel_data[e];
          // Reserve beats a same-cycle write so a re-issued producer stays pending.
          if (bus.clr_req)                  pending[e] <= 1'b0;
          else if (bus.rsv_en && rsv_oh[e]) pending[e] <= 1'b1;
          else if (strobe[e])               pending[e] <= 1'b0;
        end
      end
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [AW-1:0] addr;
    logic          byp;
    assign addr = bus.rd_addr[k*AW +: AW];
    assign byp  = (BYPASS != 0) && (state == ST_IDLE) && strobe[addr];
    assign bus.rd_data[k*WIDTH +: WIDTH] = (ZERO_REG != 0 && addr == '0) ? '0
                                         : byp ? sel_data[addr] : mem[addr];
    assign bus.rd_pending[k] = pending[addr];
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench: default DUT (x0 zero, bypass) and alternate DUT (no x0, no bypass) share stimulus.
module tb_regfile_mp;

  logic clk = 1'b0;
  logic areset;
  always #5 clk = ~clk;

  regfile_mp_if #(.WIDTH(32), .AW(5), .NUM_RD(2), .NUM_WR(2)) bus ();
  regfile_mp_if #(.WIDTH(32), .AW(5), .NUM_RD(2), .NUM_WR(2)) bus_a ();

  assign bus_a.rd_addr  = bus.rd_addr;
  assign bus_a.wr_en    = bus.wr_en;
  assign bus_a.wr_addr  = bus.wr_addr;
  assign bus_a.wr_data  = bus.wr_data;
  assign bus_a.rsv_en   = bus.rsv_en;
  assign bus_a.rsv_addr = bus.rsv_addr;
  assign bus_a.clr_req  = bus.clr_req;

  regfile_mp #(.WIDTH(32), .ENTRIES(32), .AW(5), .NUM_RD(2), .NUM_WR(2),
               .ZERO_REG(1), .BYPASS(1)) u_dut (.clk(clk), .areset(areset), .bus(bus));
  regfile_mp #(.WIDTH(32), .ENTRIES(32), .AW(5), .NUM_RD(2), .NUM_WR(2),
               .ZERO_REG(0), .BYPASS(0)) u_alt (.clk(clk), .areset(areset), .bus(bus_a));

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } exp_t;

  exp_t        q[$];
  logic [31:0] mz[32];
  logic [31:0] ma[32];
  logic [31:0] pz, pa;
  bit          m_busy;
  int          m_cnt;
  bit          obs_busy;
  int          n_chk  = 0;
  int          n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin mz[i] = '0; ma[i] = '0; end
    pz = '0; pa = '0; m_busy = 0; m_cnt = 0;
  endtask

  task automatic idle_in();
    bus.rd_addr = '0; bus.wr_en = '0; bus.wr_addr = '0; bus.wr_data = '0;
    bus.rsv_en = 1'b0; bus.rsv_addr = '0; bus.clr_req = 1'b0;
  endtask

  task automatic set_wr(input int p, input logic [4:0] a, input logic [31:0] d);
    bus.wr_en[p] = 1'b1;
    bus.wr_addr[p*5 +: 5] = a;
    bus.wr_data[p*32 +: 32] = d;
  endtask

  task automatic set_rd(input logic [4:0] a0, input logic [4:0] a1);
    bus.rd_addr = {a1, a0};
  endtask

  task automatic model_update();
    logic [4:0] a;
    if (m_busy) begin
      mz[m_cnt] = '0; ma[m_cnt] = '0;
      if (m_cnt == 31) m_busy = 0;
      m_cnt = (m_cnt + 1) % 32;
    end else begin
      for (int p = 0; p < 2; p++) begin
        if (bus.wr_en[p]) begin
          a = bus.wr_addr[p*5 +: 5];
          if (a != 0) begin mz[a] = bus.wr_data[p*32 +: 32]; pz[a] = 1'b0; end
          ma[a] = bus.wr_data[p*32 +: 32]; pa[a] = 1'b0;
        end
      end
      if (bus.rsv_en) begin
        if (bus.rsv_addr != 0) pz[bus.rsv_addr] = 1'b1;
        pa[bus.rsv_addr] = 1'b1;
      end
      if (bus.clr_req) begin
        pz = '0; pa = '0; m_busy = 1; m_cnt = 0;
      end
    end
  endtask

  // One clock: queue expectations from the model, compare mid-cycle, then advance the model.
  task automatic step();
    logic [4:0]  a;
    logic [31:0] bv;
    bit          byp;
    exp_t        e;
    for (int k = 0; k < 2; k++) begin
      a = bus.rd_addr[k*5 +: 5];
      byp = 0; bv = '0;
      for (int p = 0; p < 2; p++)
        if (bus.wr_en[p] && bus.wr_addr[p*5 +: 5] == a) begin byp = 1; bv = bus.wr_data[p*32 +: 32]; end
      q.push_back('{tag: $sformatf("rd%0d_x%0d", k, a),
                    exp: (a == 0) ? 32'h0 : (byp && !m_busy) ? bv : mz[a]});
      q.push_back('{tag: $sformatf("pend%0d_x%0d", k, a), exp: 32'(pz[a])});
      q.push_back('{tag: $sformatf("alt_rd%0d_x%0d", k, a), exp: ma[a]});
      q.push_back('{tag: $sformatf("alt_pend%0d_x%0d", k, a), exp: 32'(pa[a])});
    end
    q.push_back('{tag: "busy", exp: 32'(m_busy)});
    q.push_back('{tag: "done", exp: 32'(m_busy && m_cnt == 31)});
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      e = q.pop_front(); chk(e.tag, bus.rd_data[k*32 +: 32], e.exp);
      e = q.pop_front(); chk(e.tag, 32'(bus.rd_pending[k]), e.exp);
      e = q.pop_front(); chk(e.tag, bus_a.rd_data[k*32 +: 32], e.exp);
      e = q.pop_front(); chk(e.tag, 32'(bus_a.rd_pending[k]), e.exp);
    end
    e = q.pop_front(); chk(e.tag, 32'(bus.clr_busy), e.exp);
    e = q.pop_front(); chk(e.tag, 32'(bus.clr_done), e.exp);
    obs_busy = bus.clr_busy;
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic sweep();
    for (int i = 0; i < 16; i++) begin
      idle_in(); set_rd(5'(2*i), 5'(2*i + 1)); step();
    end
  endtask

  task automatic release_reset();
    @(negedge clk); areset = 1'b0;
    @(posedge clk); #1;
  endtask

  int busy_cycles;

  initial begin
    idle_in();
    areset = 1'b1;
    model_reset();
    #1;
    chk("reset_busy", 32'(bus.clr_busy), 32'h0);
    chk("reset_done", 32'(bus.clr_done), 32'h0);
    release_reset();

    // Basic write and readback on both ports
    idle_in(); set_wr(0, 5'd5, 32'hDEADBEEF); set_rd(5'd5, 5'd5); step();
    idle_in(); set_rd(5'd5, 5'd5); step();
    sweep();

    // x0 write plus reserve
    idle_in(); set_wr(0, 5'd0, 32'h1234); bus.rsv_en = 1'b1; bus.rsv_addr = 5'd0; set_rd(5'd0, 5'd0); step();
    idle_in(); set_rd(5'd0, 5'd5); step();

    // Same-address write conflict
    idle_in(); set_wr(0, 5'd7, 32'h11); set_wr(1, 5'd7, 32'h22); set_rd(5'd7, 5'd7); step();
    idle_in(); set_rd(5'd7, 5'd7); step();

    // Scoreboard set / reserve-wins / clear
    idle_in(); bus.rsv_en = 1'b1; bus.rsv_addr = 5'd3; set_rd(5'd3, 5'd3); step();
    idle_in(); set_wr(0, 5'd3, 32'h33); bus.rsv_en = 1'b1; bus.rsv_addr = 5'd3; set_rd(5'd3, 5'd3); step();
    idle_in(); set_rd(5'd3, 5'd3); step();
    idle_in(); set_wr(1, 5'd3, 32'h34); set_rd(5'd3, 5'd3); step();
    idle_in(); set_rd(5'd3, 5'd0); step();

    // Random traffic over a small address window
    for (int i = 0; i < 80; i++) begin
      idle_in();
      for (int p = 0; p < 2; p++)
        if ($urandom_range(0, 1) == 1) set_wr(p, 5'($urandom_range(0, 7)), $urandom);
      bus.rsv_en = 1'($urandom_range(0, 1));
      bus.rsv_addr = 5'($urandom_range(0, 7));
      set_rd(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
      step();
    end

    // Fill, reserve x9, soft clear
    for (int i = 0; i < 16; i++) begin
      idle_in(); set_wr(0, 5'(2*i), 32'hA5A5A5A5); set_wr(1, 5'(2*i + 1), 32'hA5A5A5A5);
      if (i == 15) begin bus.rsv_en = 1'b1; bus.rsv_addr = 5'd9; end
      set_rd(5'd9, 5'(2*i)); step();
    end
    idle_in(); bus.clr_req = 1'b1; set_rd(5'd9, 5'd1); step();
    busy_cycles = 0;
    for (int i = 0; i < 34; i++) begin
      idle_in();
      if (i == 5) bus.clr_req = 1'b1;
      if (i == 20) begin set_wr(1, 5'd4, 32'h0BAD0BAD); bus.rsv_en = 1'b1; bus.rsv_addr = 5'd4; end
      set_rd(5'd4, 5'(i % 32));
      step();
      if (obs_busy) busy_cycles++;
    end
    chk("clear_busy_len", 32'(busy_cycles), 32'd32);
    sweep();

    // Reset in the middle of a clear
    idle_in(); set_wr(0, 5'd20, 32'h55); set_wr(1, 5'd31, 32'h66); step();
    idle_in(); bus.clr_req = 1'b1; step();
    for (int i = 0; i < 10; i++) begin idle_in(); set_rd(5'd20, 5'd31); step(); end
    areset = 1'b1;
    #1;
    chk("midclr_busy", 32'(bus.clr_busy), 32'h0);
    chk("midclr_done", 32'(bus.clr_done), 32'h0);
    model_reset();
    idle_in();
    release_reset();
    sweep();
    idle_in(); bus.clr_req = 1'b1; step();
    busy_cycles = 0;
    for (int i = 0; i < 34; i++) begin
      idle_in(); set_rd(5'(i % 32), 5'd20); step();
      if (obs_busy) busy_cycles++;
    end
    chk("reclear_busy_len", 32'(busy_cycles), 32'd32);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
